iram_port_arbiter: RTL and testbench

//  Shares the single synchronous-read instruction RAM between two read requesters.

---
 rtl/iram_port_arbiter_if.sv | 41 ++++
 rtl/iram_port_arbiter.sv | 106 ++++++++++
 tb/tb_iram_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/iram_port_arbiter_if.sv
// Bundles the fetch (A), debug/loader (B) and IRAM-side signals of the IRAM port arbiter.
// Handshake: xReq is a level request; xGnt is same-cycle acceptance; xValid/xData follow one cycle later.
interface iram_port_arbiter_if #(
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int MAX_WAIT = 4,
   parameter int WW       = $clog2(MAX_WAIT + 1)
);
   logic          i_AReq;
   logic [AW-1:0] i_AAddr;
   logic          i_AFlush;
   logic          o_AGnt;
   logic          o_AValid;
   logic [31:0]   o_AData;

   logic          i_BReq;
   logic [AW-1:0] i_BAddr;
   logic          o_BGnt;
   logic          o_BValid;
   logic [31:0]   o_BData;

   logic          o_RamRdEn;
   logic          o_RamOZero;
   logic [AW-1:0] o_RamAddr;
   logic [31:0]   i_RamInst;

   logic [1:0]    o_DbgOwner;
   logic [WW-1:0] o_DbgBWait;

   modport slave (
      input  i_AReq, i_AAddr, i_AFlush, i_BReq, i_BAddr, i_RamInst,
      output o_AGnt, o_AValid, o_AData, o_BGnt, o_BValid, o_BData,
             o_RamRdEn, o_RamOZero, o_RamAddr, o_DbgOwner, o_DbgBWait
   );

   modport master (
      output i_AReq, i_AAddr, i_AFlush, i_BReq, i_BAddr, i_RamInst,
      input  o_AGnt, o_AValid, o_AData, o_BGnt, o_BValid, o_BData,
             o_RamRdEn, o_RamOZero, o_RamAddr, o_DbgOwner, o_DbgBWait
   );
endinterface

// File: rtl/iram_port_arbiter.sv
// Two-requester arbiter for the synchronous-read IRAM: fetch (A) has priority,
// debug/loader (B) is protected from starvation by a saturating wait counter.
module iram_port_arbiter #(
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int MAX_WAIT = 4
) (
   input  logic                i_Clk,
   input  logic                i_nRst,
   iram_port_arbiter_if.slave  bus
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] MAX_WAIT_W = WW'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   owner_t        r_Owner;
   owner_t        w_OwnerNext;
   logic [WW-1:0] r_BWait;
   logic [WW-1:0] w_BWaitNext;
   logic          w_AGnt;
   logic          w_BGnt;
   logic [AW-1:0] w_RamAddr;
   logic          w_AValid;
   logic          w_BValid;
   logic          w_RamOZero;

   // B wins when A is absent, A is being flushed, or B has waited long enough.
   always_comb begin
      w_BGnt = i_nRst & bus.i_BReq &
               (~bus.i_AReq | bus.i_AFlush | (r_BWait == MAX_WAIT_W));
      w_AGnt = i_nRst & bus.i_AReq & ~bus.i_AFlush & ~w_BGnt;
      w_RamAddr = w_BGnt ? bus.i_BAddr : bus.i_AAddr;
   end

   always_comb begin
      w_BWaitNext = r_BWait;
      if (!bus.i_BReq || w_BGnt) begin
         w_BWaitNext = '0;
      end else if (r_BWait != MAX_WAIT_W) begin
         w_BWaitNext = r_BWait + WW'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         r_BWait <= '0;
      end else begin
         r_BWait <= w_BWaitNext;
      end
   end

   // Owner remembers who the word arriving next cycle belongs to.
   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         r_Owner <= OWN_NONE;
      end else begin
         r_Owner <= w_OwnerNext;
      end
   end

   always_comb begin
      w_OwnerNext = OWN_NONE;
      w_AValid    = 1'b0;
      w_BValid    = 1'b0;
      w_RamOZero  = 1'b0;
      if (w_AGnt) begin
         w_OwnerNext = OWN_A;
      end else if (w_BGnt) begin
         w_OwnerNext = OWN_B;
      end
      case (r_Owner)
         OWN_A: begin
            w_AValid   = ~bus.i_AFlush;
            w_RamOZero = bus.i_AFlush;
         end
         OWN_B: begin
            w_BValid = 1'b1;
         end
         default: begin
            w_RamOZero = 1'b1;
         end
      endcase
   end

   // A flushed response is zeroed at the RAM and gated here as well.
   always_comb begin
      bus.o_AGnt     = w_AGnt;
      bus.o_BGnt     = w_BGnt;
      bus.o_RamRdEn  = w_AGnt | w_BGnt;
      bus.o_RamAddr  = w_RamAddr;
      bus.o_RamOZero = w_RamOZero;
      bus.o_AValid   = w_AValid;
      bus.o_BValid   = w_BValid;
      bus.o_AData    = w_AValid ? bus.i_RamInst : 32'h0;
      bus.o_BData    = w_BValid ? bus.i_RamInst : 32'h0;
      bus.o_DbgOwner = r_Owner;
      bus.o_DbgBWait = r_BWait;
   end

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Bench for iram_port_arbiter: directed scenarios then random traffic, with a
// reference arbitration model feeding an expected-response queue.
module tb_iram_port_arbiter;

   localparam int DEPTH    = 32;
   localparam int AW       = $clog2(DEPTH);
   localparam int MAX_WAIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iram_port_arbiter_if #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) bus();

   iram_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .i_Clk  (clk),
      .i_nRst (rst_n),
      .bus    (bus)
   );

   // Synchronous-read RAM with combinational output-zero.
   logic [31:0] mem [DEPTH];
   logic [31:0] ram_q = 32'h0;
   always @(posedge clk) if (bus.o_RamRdEn) ram_q <= mem[bus.o_RamAddr];
   assign bus.i_RamInst = bus.o_RamOZero ? 32'h0 : ram_q;

   logic [31:0] exp_q[$];
   bit          exp_who_q[$];
   int          exp_cyc_q[$];
   int          wait_m = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Reference arbitration: predicts grants, queues the word each grant must return.
   always @(negedge clk) begin
      logic eb, ea;
      if (!rst_n) begin
         wait_m = 0;
         chk("rst_a_gnt", bus.o_AGnt, 0);
         chk("rst_b_gnt", bus.o_BGnt, 0);
         chk("rst_rd_en", bus.o_RamRdEn, 0);
      end else begin
         eb = bus.i_BReq && (!bus.i_AReq || bus.i_AFlush || wait_m == MAX_WAIT);
         ea = bus.i_AReq && !bus.i_AFlush && !eb;
         chk("a_gnt", bus.o_AGnt, ea);
         chk("b_gnt", bus.o_BGnt, eb);
         chk("rd_en", bus.o_RamRdEn, ea | eb);
         chk("b_wait", bus.o_DbgBWait, wait_m);
         if (ea) begin
            chk("ram_addr_a", bus.o_RamAddr, bus.i_AAddr);
            exp_q.push_back(mem[bus.i_AAddr]);
            exp_who_q.push_back(1'b0);
            exp_cyc_q.push_back(cyc);
         end
         if (eb) begin
            chk("ram_addr_b", bus.o_RamAddr, bus.i_BAddr);
            exp_q.push_back(mem[bus.i_BAddr]);
            exp_who_q.push_back(1'b1);
            exp_cyc_q.push_back(cyc);
         end
         if (!bus.i_BReq || eb) wait_m = 0;
         else if (wait_m < MAX_WAIT) wait_m = wait_m + 1;
      end
   end

   // Monitor: every granted word must surface exactly one cycle later unless flushed.
   always @(negedge clk) begin
      logic        pa, pb;
      logic [31:0] ed;
      pa = 1'b0;
      pb = 1'b0;
      ed = 32'h0;
      if (!rst_n) begin
         exp_q.delete();
         exp_who_q.delete();
         exp_cyc_q.delete();
         chk("rst_a_valid", bus.o_AValid, 0);
         chk("rst_b_valid", bus.o_BValid, 0);
         chk("rst_a_data", bus.o_AData, 0);
         chk("rst_b_data", bus.o_BData, 0);
         chk("rst_ozero", bus.o_RamOZero, 1);
         chk("rst_b_wait", bus.o_DbgBWait, 0);
      end else begin
         if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc - 1) begin
            if (exp_who_q[0]) pb = 1'b1;
            else pa = 1'b1;
            ed = exp_q.pop_front();
            void'(exp_who_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
         chk("a_valid", bus.o_AValid, pa && !bus.i_AFlush);
         chk("a_data", bus.o_AData, (pa && !bus.i_AFlush) ? ed : 32'h0);
         chk("b_valid", bus.o_BValid, pb);
         chk("b_data", bus.o_BData, pb ? ed : 32'h0);
         chk("ram_ozero", bus.o_RamOZero, (!pa && !pb) || (pa && bus.i_AFlush));
      end
   end

   task automatic drive(input logic ar, input logic [AW-1:0] aa, input logic af,
                        input logic br, input logic [AW-1:0] ba);
      @(posedge clk);
      #1;
      bus.i_AReq   = ar;
      bus.i_AAddr  = aa;
      bus.i_AFlush = af;
      bus.i_BReq   = br;
      bus.i_BAddr  = ba;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0] = 32'h00200293;
      mem[1] = 32'h40501023;
      mem[2] = 32'h00002403;
      bus.i_AReq   = 1'b0;
      bus.i_AAddr  = '0;
      bus.i_AFlush = 1'b0;
      bus.i_BReq   = 1'b0;
      bus.i_BAddr  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset.
      idle(10);

      // Back-to-back A reads.
      for (int i = 0; i < 3; i++) drive(1'b1, AW'(i), 1'b0, 1'b0, '0);
      idle(2);

      // A continuous, B starved until the guard trips.
      for (int i = 0; i < 6; i++) drive(1'b1, AW'(i + 8), 1'b0, (i < 5), AW'(5));
      idle(2);

      // A grant followed by flush.
      drive(1'b1, AW'(3), 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      idle(3);

      // Flush with both requesting: B wins.
      drive(1'b1, AW'(4), 1'b1, 1'b1, AW'(7));
      idle(2);

      // Reset lands on the cycle after a B grant.
      drive(1'b0, '0, 1'b0, 1'b1, AW'(9));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.i_BReq = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, AW'(2), 1'b0, 1'b0, '0);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, DEPTH - 1)),
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 4, AW'($urandom_range(0, DEPTH - 1)));
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
